// File: rtl/nanorv32_wb_stage_pkg.sv
// nanorv32_wb_stage_pkg: shared widths, execute-kind/load-size encodings and writeback FSM states
package nanorv32_wb_stage_pkg;
  localparam int DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_DIV  = 2'b01,
    KIND_LOAD = 2'b10,
    KIND_NONE = 2'b11
  } kind_e;
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_e;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DIV  = 2'b01,
    WAIT_LOAD = 2'b10
  } state_e;
endpackage

// File: rtl/nanorv32_load_fmt.sv
// nanorv32_load_fmt: combinational load lane select with sign/zero extension
module nanorv32_load_fmt
  import nanorv32_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [1:0]  offset,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[8*offset +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = size == LD_BYTE ? {{24{~unsigned_ld & b[7]}}, b} :
           size == LD_HALF ? {{16{~unsigned_ld & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/nanorv32_wb_stage.sv
// nanorv32_wb_stage: writeback sequencing for ALU/div/load results; NANORV32_WB_FORWARD_EN adds a capture-cycle bypass
module nanorv32_wb_stage
  import nanorv32_wb_stage_pkg::*;
#(
  parameter int NANORV32_DATA_W    = DATA_W,
  parameter int NANORV32_RF_ADDR_W = RF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic [1:0]                    ex_kind,
  input  logic                          ex_rd_we,
  input  logic [NANORV32_RF_ADDR_W-1:0] ex_rd_addr,
  input  logic [1:0]                    ex_ld_size,
  input  logic                          ex_ld_unsigned,
  input  logic [1:0]                    ex_ld_offset,
  input  logic [NANORV32_DATA_W-1:0]    alu_res,
  input  logic                          div_ready,
  input  logic                          dmem_rvalid,
  input  logic [NANORV32_DATA_W-1:0]    dmem_rdata,
  output logic                          wb_stall,
  output logic                          rf_we,
  output logic [NANORV32_RF_ADDR_W-1:0] rf_waddr,
  output logic [NANORV32_DATA_W-1:0]    rf_wdata,
  output logic                          wb_retire
`ifdef NANORV32_WB_FORWARD_EN
  ,
  output logic                          fwd_valid,
  output logic [NANORV32_RF_ADDR_W-1:0] fwd_addr,
  output logic [NANORV32_DATA_W-1:0]    fwd_data
`endif
);
  state_e                        state;
  logic [NANORV32_RF_ADDR_W-1:0] pend_addr;
  logic                          pend_we;
  logic [1:0]                    pend_size;
  logic                          pend_uns;
  logic [1:0]                    pend_off;
  logic                          in_idle, in_load, cap, cap_we;
  logic [NANORV32_RF_ADDR_W-1:0] cap_addr;
  logic [NANORV32_DATA_W-1:0]    cap_data, ld_data;
  assign in_idle = state == IDLE;
  assign in_load = state == WAIT_LOAD;
  assign wb_stall = state == WAIT_DIV ? ~div_ready : in_load ? ~dmem_rvalid : 1'b0;
  // A fast response in IDLE formats from the live execute fields, a slow one from the latched copy
  nanorv32_load_fmt u_fmt (
    .rdata      (dmem_rdata),
    .size       (in_load ? pend_size : ex_ld_size),
    .unsigned_ld(in_load ? pend_uns : ex_ld_unsigned),
    .offset     (in_load ? pend_off : ex_ld_offset),
    .data       (ld_data)
  );
  assign cap = in_idle ? ex_valid && (ex_kind == KIND_ALU || ex_kind == KIND_NONE ||
                                      (ex_kind == KIND_DIV && div_ready) ||
                                      (ex_kind == KIND_LOAD && dmem_rvalid))
                       : state == WAIT_DIV ? div_ready : dmem_rvalid;
  assign cap_we = in_idle ? ex_rd_we && ex_rd_addr != '0 && ex_kind != KIND_NONE : pend_we;
  assign cap_addr = in_idle ? ex_rd_addr : pend_addr;
  assign cap_data = (in_idle ? ex_kind == KIND_LOAD : in_load) ? ld_data : alu_res;
`ifdef NANORV32_WB_FORWARD_EN
  assign fwd_valid = cap && cap_we;
  assign fwd_addr = cap_addr;
  assign fwd_data = cap_data;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_retire <= 1'b0;
      pend_addr <= '0;
      pend_we <= 1'b0;
      pend_size <= '0;
      pend_uns <= 1'b0;
      pend_off <= '0;
    end else begin
      rf_we <= cap && cap_we;
      wb_retire <= cap;
      if (cap) begin
        rf_waddr <= cap_addr;
        rf_wdata <= cap_data;
        state <= IDLE;
      end else if (in_idle && ex_valid) begin
        state <= ex_kind == KIND_DIV ? WAIT_DIV : WAIT_LOAD;
        pend_addr <= ex_rd_addr;
        pend_we <= ex_rd_we && ex_rd_addr != '0;
        pend_size <= ex_ld_size;
        pend_uns <= ex_ld_unsigned;
        pend_off <= ex_ld_offset;
      end
    end
  end
endmodule

// File: tb/tb_nanorv32_wb_stage.sv
// tb_nanorv32_wb_stage: directed plus random writeback transactions checked against a behavioural model
module tb_nanorv32_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_kind = '0;
  logic        ex_rd_we = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic [1:0]  ex_ld_size = '0;
  logic        ex_ld_unsigned = 1'b0;
  logic [1:0]  ex_ld_offset = '0;
  logic [31:0] alu_res = '0;
  logic        div_ready = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_stall, rf_we, wb_retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef NANORV32_WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif
  int total = 0;
  int bad = 0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  nanorv32_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_rd_we(ex_rd_we),
    .ex_rd_addr(ex_rd_addr), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .ex_ld_offset(ex_ld_offset), .alu_res(alu_res), .div_ready(div_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_stall(wb_stall), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_retire(wb_retire)
`ifdef NANORV32_WB_FORWARD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected load value from byte counts and shifts
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    int nbytes, lane;
    logic [31:0] mask, v;
    nbytes = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    lane = size == 2'd0 ? int'(off) : size == 2'd1 ? int'(off) / 2 * 2 : 0;
    v = w >> (8 * lane);
    if (nbytes < 4) begin
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      v = v & mask;
      if (!uns && v[8*nbytes-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic run(input logic [1:0] kind, input logic [4:0] rd, input logic we,
                     input logic [1:0] size, input logic uns, input logic [1:0] off,
                     input int delay, input logic [31:0] val);
    int stalls;
    logic waits;
    waits = (kind == 2'd1 || kind == 2'd2) && delay > 0;
    ex_valid = 1'b1; ex_kind = kind; ex_rd_addr = rd; ex_rd_we = we;
    ex_ld_size = size; ex_ld_unsigned = uns; ex_ld_offset = off;
    alu_res = (kind == 2'd2 || (kind == 2'd1 && waits)) ? $urandom : val;
    dmem_rdata = (kind == 2'd2 && !waits) ? val : $urandom;
    div_ready = kind == 2'd1 && !waits;
    dmem_rvalid = kind == 2'd2 && !waits;
    #1 chk("stall_issue", {31'd0, wb_stall}, 32'd0);
    stalls = 0;
    if (waits) begin
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
        div_ready = 1'b0; dmem_rvalid = 1'b0; alu_res = $urandom; dmem_rdata = $urandom;
        #1 if (wb_stall) stalls++;
      end
      @(posedge clk); #1;
      if (kind == 2'd1) begin div_ready = 1'b1; alu_res = val; end
      else begin dmem_rvalid = 1'b1; dmem_rdata = val; end
      #1 chk("stall_done", {31'd0, wb_stall}, 32'd0);
      chk("stall_cycles", stalls, delay);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; div_ready = 1'b0; dmem_rvalid = 1'b0;
    exp_addr = rd;
    exp_data = kind == 2'd2 ? load_val(val, size, uns, off) : val;
    chk("rf_we", {31'd0, rf_we}, {31'd0, we && rd != 5'd0 && kind != 2'd3});
    chk("retire", {31'd0, wb_retire}, 32'd1);
    chk("waddr", {27'd0, rf_waddr}, {27'd0, exp_addr});
    chk("wdata", rf_wdata, exp_data);
    @(posedge clk); #1;
    chk("rf_we_pulse", {31'd0, rf_we}, 32'd0);
    chk("retire_pulse", {31'd0, wb_retire}, 32'd0);
    chk("waddr_hold", {27'd0, rf_waddr}, {27'd0, exp_addr});
    chk("wdata_hold", rf_wdata, exp_data);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_retire", {31'd0, wb_retire}, 32'd0);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(2'd0, 5'd5, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h1234_5678);
    run(2'd1, 5'd7, 1'b1, 2'd2, 1'b0, 2'd0, 33, 32'hFFFF_FFFD);
    run(2'd2, 5'd9, 1'b1, 2'd0, 1'b0, 2'd2, 3, 32'h0080_0000);
    run(2'd2, 5'd9, 1'b1, 2'd0, 1'b1, 2'd2, 3, 32'h0080_0000);
    run(2'd2, 5'd10, 1'b1, 2'd1, 1'b0, 2'd2, 2, 32'h8001_1234);
    run(2'd2, 5'd11, 1'b1, 2'd1, 1'b0, 2'd3, 0, 32'h8001_1234);
    run(2'd2, 5'd12, 1'b1, 2'd3, 1'b0, 2'd1, 1, 32'hCAFE_F00D);
    run(2'd0, 5'd0, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'hDEAD_BEEF);
    run(2'd3, 5'd4, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h0000_0042);
    run(2'd1, 5'd3, 1'b1, 2'd2, 1'b0, 2'd0, 0, 32'h7777_0001);
    // Stray responses with no instruction pending
    div_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA; alu_res = 32'h1111_2222;
    #1 chk("stray_stall", {31'd0, wb_stall}, 32'd0);
    @(posedge clk); #1;
    div_ready = 1'b0; dmem_rvalid = 1'b0;
    chk("stray_we", {31'd0, rf_we}, 32'd0);
    chk("stray_retire", {31'd0, wb_retire}, 32'd0);
    chk("stray_wdata", rf_wdata, exp_data);
    // Reset while a load is outstanding drops it
    ex_valid = 1'b1; ex_kind = 2'd2; ex_rd_addr = 5'd6; ex_rd_we = 1'b1; ex_ld_size = 2'd2;
    @(posedge clk); #1;
    #1 chk("pre_rst_stall", {31'd0, wb_stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("mid_rst_wdata", rf_wdata, 32'd0);
    exp_addr = '0; exp_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; ex_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_8888;
    #1 chk("post_rst_stall", {31'd0, wb_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("post_rst_we", {31'd0, rf_we}, 32'd0);
    chk("post_rst_retire", {31'd0, wb_retire}, 32'd0);
    chk("post_rst_wdata", rf_wdata, 32'd0);
    for (int n = 0; n < 40; n++) begin
      run(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
          2'($urandom), $urandom_range(0, 3), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
